// File: rtl/hq2x_vga_pkg.sv
// hq2x_vga_pkg: timing defaults, raster total derivations and the 15-bit pixel type for hq2x_vga_out
package hq2x_vga_pkg;

    localparam int CW = 12;

    localparam int H_IMG_DEF    = 512;
    localparam int H_BORDER_DEF = 64;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_IMG_DEF    = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef struct packed {
        logic [4:0] b;
        logic [4:0] g;
        logic [4:0] r;
    } rgb15_t;

    function automatic int h_total(input int img, input int border, input int fp, input int sync, input int bp);
        return 2 * border + img + fp + sync + bp;
    endfunction

    function automatic int v_total(input int img, input int fp, input int sync, input int bp);
        return img + fp + sync + bp;
    endfunction

    localparam int H_TOTAL = h_total(H_IMG_DEF, H_BORDER_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL = v_total(V_IMG_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/hq2x_vga_out_if.sv
// hq2x_vga_out_if: read-side link between the VGA output stage (master) and the hq2x upscaler (slave)
interface hq2x_vga_out_if;
    logic [14:0] outpixel;
    logic        frame_available;
    logic [9:0]  read_x;
    logic        reset_line;
    logic        reset_frame;

    modport master (input outpixel, frame_available, output read_x, reset_line, reset_frame);
    modport slave  (output outpixel, frame_available, input read_x, reset_line, reset_frame);
endinterface

// File: rtl/hq2x_vga_out_video_counter.sv
// video_counter: h/v raster counters advancing on ce_pix, with region flags and sync windows
module video_counter
    import hq2x_vga_pkg::*;
#(
    parameter int H_IMG    = H_IMG_DEF,
    parameter int H_BORDER = H_BORDER_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_IMG    = V_IMG_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce_pix_i,
    output logic [CW-1:0] h_o,
    output logic          v_odd_o,
    output logic          vis_o,
    output logic          img_o,
    output logic          hs_o,
    output logic          vs_o
);
    localparam logic [CW-1:0] H_LAST  = CW'(h_total(H_IMG, H_BORDER, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(v_total(V_IMG, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [CW-1:0] VIS_END = CW'(2 * H_BORDER + H_IMG);
    localparam logic [CW-1:0] IMG_BEG = CW'(H_BORDER);
    localparam logic [CW-1:0] IMG_END = CW'(H_BORDER + H_IMG);
    localparam logic [CW-1:0] HS_BEG  = CW'(2 * H_BORDER + H_IMG + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(2 * H_BORDER + H_IMG + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_VIS   = CW'(V_IMG);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_IMG + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_IMG + V_FP + V_SYNC);

    logic [CW-1:0] h_q, h_d, v_q, v_d;

    // Next raster position: h wraps at end of line and only then steps v
    always_comb begin
        h_d = (h_q == H_LAST) ? '0 : h_q + CW'(1);
        v_d = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + CW'(1);
    end

    // Raster position register, advanced once per pixel tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q <= '0;
            v_q <= '0;
        end else if (ce_pix_i) begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_o     = h_q;
    assign v_odd_o = v_q[0];
    assign vis_o   = (h_q < VIS_END) && (v_q < V_VIS);
    assign img_o   = vis_o && (h_q >= IMG_BEG) && (h_q < IMG_END);
    assign hs_o    = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs_o    = (v_q >= VS_BEG) && (v_q < VS_END);
endmodule

// File: rtl/hq2x_vga_out.sv
// hq2x_vga_out: VGA timing and pixel output stage reading the hq2x upscaler line buffer.
// Define HQ2X_VGA_OUT_SCANLINES_EN to halve image colour on odd lines (scanline effect).
module hq2x_vga_out
    import hq2x_vga_pkg::*;
#(
    parameter int H_IMG    = H_IMG_DEF,
    parameter int H_BORDER = H_BORDER_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_IMG    = V_IMG_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce_pix,
    hq2x_vga_out_if.master        up,
    output logic [4:0]            vga_r,
    output logic [4:0]            vga_g,
    output logic [4:0]            vga_b,
    output logic                  hsync_n,
    output logic                  vsync_n,
    output logic                  de
);
    logic [CW-1:0] h;
    logic          v_odd, vis, img, hs, vs;
    logic [8:0]    col;
    logic [9:0]    read_x_d, read_x_q;
    logic          img_q, vis_q, hs_q, vs_q, reset_line_q, reset_frame_q;
    rgb15_t        pix_d, pix_q;
    logic          de_q, hsync_n_q, vsync_n_q;

    video_counter #(
        .H_IMG(H_IMG), .H_BORDER(H_BORDER), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_IMG(V_IMG), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_cnt (
        .clk(clk), .reset_n(reset_n), .ce_pix_i(ce_pix),
        .h_o(h), .v_odd_o(v_odd), .vis_o(vis), .img_o(img), .hs_o(hs), .vs_o(vs)
    );

    assign col      = 9'(h - CW'(H_BORDER));
    assign read_x_d = {v_odd, img ? col : 9'd0};

    // Stage 1: upscaler read address and the flags that travel with it to the colour stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_x_q      <= '0;
            img_q         <= 1'b0;
            vis_q         <= 1'b0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            reset_line_q  <= 1'b0;
            reset_frame_q <= 1'b1;
        end else if (ce_pix) begin
            read_x_q      <= read_x_d;
            img_q         <= img;
            vis_q         <= vis;
            hs_q          <= hs;
            vs_q          <= vs;
            reset_line_q  <= hs && v_odd;
            reset_frame_q <= vs;
        end
    end

    // Colour select: upscaler pixel inside the image, black elsewhere, optionally dimmed on odd lines
    always_comb begin
        pix_d = img_q ? rgb15_t'(up.outpixel) : '0;
`ifdef HQ2X_VGA_OUT_SCANLINES_EN
        if (read_x_q[9]) begin
            pix_d.r = pix_d.r >> 1;
            pix_d.g = pix_d.g >> 1;
            pix_d.b = pix_d.b >> 1;
        end
`endif
    end

    // Stage 2: colour, data enable and syncs, one tick behind read_x so outpixel lines up
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_q     <= '0;
            de_q      <= 1'b0;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
        end else if (ce_pix) begin
            pix_q     <= pix_d;
            de_q      <= vis_q;
            hsync_n_q <= !hs_q;
            vsync_n_q <= !vs_q;
        end
    end

    assign up.read_x      = read_x_q;
    assign up.reset_line  = reset_line_q;
    assign up.reset_frame = reset_frame_q;
    assign vga_r          = pix_q.r;
    assign vga_g          = pix_q.g;
    assign vga_b          = pix_q.b;
    assign de             = de_q;
    assign hsync_n        = hsync_n_q;
    assign vsync_n        = vsync_n_q;
endmodule

// File: tb/tb_hq2x_vga_out.sv
// tb_hq2x_vga_out: directed checks of raster timing, pixel path, ce gating and reset for hq2x_vga_out
module tb_hq2x_vga_out;
    logic clk = 1'b0, reset_n = 1'b0, ce_pix = 1'b0, ce_en = 1'b0;
    int   total = 0, passed = 0;

    logic [4:0]  vga_r, vga_g, vga_b, s_r, s_g, s_b;
    logic        hsync_n, vsync_n, de, s_hs_n, s_vs_n, s_de;
    logic [14:0] col;

`ifdef HQ2X_VGA_OUT_SCANLINES_EN
    localparam logic [14:0] ODD_COL5 = 15'd2;
`else
    localparam logic [14:0] ODD_COL5 = 15'd5;
`endif

    hq2x_vga_out_if bus();
    hq2x_vga_out_if sbus();

    // Upscaler stand-in: pixel value equals the requested column
    assign bus.outpixel         = {6'd0, bus.read_x[8:0]};
    assign bus.frame_available  = 1'b1;
    assign sbus.outpixel        = {6'd0, sbus.read_x[8:0]};
    assign sbus.frame_available = 1'b1;
    assign col                  = {vga_b, vga_g, vga_r};

    hq2x_vga_out dut (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .up(bus),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de)
    );

    // Small raster (31 x 13) so whole frames fit in a short run
    hq2x_vga_out #(
        .H_IMG(16), .H_BORDER(4), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_IMG(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) sdut (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .up(sbus),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .hsync_n(s_hs_n), .vsync_n(s_vs_n), .de(s_de)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        ce_pix = ce_en && !ce_pix;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (ce_pix !== 1'b1 && n < 8);
        if (ce_pix !== 1'b1) begin
            total++;
            $error("FAIL tick_timeout observed=no_ce expected=ce_within_8_clk");
        end
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_read_x"}, 32'(bus.read_x), 0);
        chk({tag, "_colour"}, 32'(col), 0);
        chk({tag, "_de"}, 32'(de), 0);
        chk({tag, "_hsync_n"}, 32'(hsync_n), 1);
        chk({tag, "_vsync_n"}, 32'(vsync_n), 1);
        chk({tag, "_reset_line"}, 32'(bus.reset_line), 0);
        chk({tag, "_reset_frame"}, 32'(bus.reset_frame), 1);
    endtask

    initial begin
        int  hs_fall1 = 0, hs_rise1 = 0, hs_fall2 = 0, hs_fall3 = 0, vs_low_big = 0;
        int  s_rl_rises = 0, s_rf_first = 0, s_rf_cnt = 0, s_vs_first = 0, s_vs_cnt = 0;
        int  s_vs_fall1 = 0, s_vs_fall2 = 0, s_hs_fall1 = 0, first_low = 0;
        logic hs_prev = 1'b1, s_rl_prev = 1'b0, s_vs_prev = 1'b1, s_hs_prev = 1'b1;

        ce_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk_reset_state("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Ticks are numbered from release; outputs at tick k show raster state k-2, read_x shows k-1
        for (int k = 1; k <= 2300; k++) begin
            if (k == 1701) begin
                ce_en = 1'b0;
                repeat (50) @(posedge clk);
                #1;
                chk("freeze_colour", 32'(col), 34);
                chk("freeze_read_x", 32'(bus.read_x), 35);
                chk("freeze_de", 32'(de), 1);
                chk("freeze_hsync_n", 32'(hsync_n), 1);
                ce_en = 1'b1;
            end
            tick();
            if (hs_prev && !hsync_n) begin
                if (hs_fall1 == 0) hs_fall1 = k;
                else if (hs_fall2 == 0) hs_fall2 = k;
                else if (hs_fall3 == 0) hs_fall3 = k;
            end
            if (!hs_prev && hsync_n && hs_rise1 == 0) hs_rise1 = k;
            hs_prev = hsync_n;
            if (!vsync_n) vs_low_big++;
            if (s_hs_prev && !s_hs_n && s_hs_fall1 == 0) s_hs_fall1 = k;
            s_hs_prev = s_hs_n;
            if (s_vs_prev && !s_vs_n) begin
                if (s_vs_fall1 == 0) s_vs_fall1 = k;
                else if (s_vs_fall2 == 0) s_vs_fall2 = k;
            end
            s_vs_prev = s_vs_n;
            if (k <= 403) begin
                if (!s_rl_prev && sbus.reset_line) s_rl_rises++;
                if (sbus.reset_frame) begin
                    if (s_rf_first == 0) s_rf_first = k;
                    s_rf_cnt++;
                end
                if (!s_vs_n) begin
                    if (s_vs_first == 0) s_vs_first = k;
                    s_vs_cnt++;
                end
            end
            s_rl_prev = sbus.reset_line;
            if (k == 1) chk("read_x_h0", 32'(bus.read_x), 0);
            if (k == 1) chk("de_pipeline_fill", 32'(de), 0);
            if (k == 2) chk("left_border_de", 32'(de), 1);
            if (k == 2) chk("left_border_colour", 32'(col), 0);
            if (k == 70) chk("read_x_col5", 32'(bus.read_x), 5);
            if (k == 71) chk("colour_col5", 32'(col), 5);
            if (k == 106) chk("colour_col40", 32'(col), 40);
            if (k == 577) chk("colour_col511", 32'(col), 511);
            if (k == 578) chk("right_border_de_colour", 32'({de, col}), 32'h8000);
            if (k == 642) chk("blank_de", 32'(de), 0);
            if (k == 657) chk("reset_line_even", 32'(bus.reset_line), 0);
            if (k == 1456) chk("reset_line_before", 32'(bus.reset_line), 0);
            if (k == 1457) chk("reset_line_odd", 32'(bus.reset_line), 1);
            if (k == 870) chk("read_x_odd_col5", 32'(bus.read_x), 32'h205);
            if (k == 871) chk("colour_odd_col5", 32'(col), 32'(ODD_COL5));
            if (k == 2300) chk("hsync_low_mid_pulse", 32'(hsync_n), 0);
        end

        // hsync_n is low for h=656..751, appearing two pipeline ticks after the counter
        chk("hsync_first_fall", hs_fall1, 658);
        chk("hsync_width", hs_rise1 - hs_fall1, 96);
        chk("line_length", hs_fall2 - hs_fall1, 800);
        chk("line_length_after_freeze", hs_fall3 - hs_fall2, 800);
        chk("no_vsync_early", vs_low_big, 0);
        chk("small_hsync_first_fall", s_hs_fall1, 28);
        chk("small_reset_line_rises", s_rl_rises, 6);
        chk("small_reset_frame_first", s_rf_first, 249);
        chk("small_reset_frame_len", s_rf_cnt, 62);
        chk("small_vsync_first", s_vs_first, 250);
        chk("small_vsync_len", s_vs_cnt, 62);
        chk("small_frame_length", s_vs_fall2 - s_vs_fall1, 403);

        // Reset asserted in the middle of an hsync pulse takes effect without a clock
        reset_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 700; k++) begin
            tick();
            if (!hsync_n && first_low == 0) first_low = k;
        end
        chk("post_reset_hsync_fall", first_low, 658);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
